// File: rtl/instruction_sequencer_pkg.sv
// rtl/instruction_sequencer_pkg.sv - shared state, class and instruction-ID definitions
package instruction_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6,
    ST_TRAP      = 3'd7
  } seq_state_e;

  typedef enum logic [3:0] {
    CLS_ILLEGAL = 4'd0,
    CLS_ALU     = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_SWI     = 4'd5,
    CLS_NOP     = 4'd6,
    CLS_HLT     = 4'd7,
    CLS_RSTW    = 4'd8,
    CLS_MISC    = 4'd9
  } instr_class_e;

  localparam logic [6:0] ID_SWI  = 7'h48;
  localparam logic [6:0] ID_B    = 7'h49;
  localparam logic [6:0] ID_BX   = 7'h26;
  localparam logic [6:0] ID_NOP  = 7'h4A;
  localparam logic [6:0] ID_HLT  = 7'h4B;
  localparam logic [6:0] ID_RSTW = 7'h64;

endpackage

// File: rtl/instruction_sequencer_if.sv
// rtl/instruction_sequencer_if.sv - sequencer <-> decoder/datapath signal bundle
interface instruction_sequencer_if;
  logic [6:0]  id;
  logic        cond_pass;
  logic        resume;
  logic        ir_load;
  logic        imem_read;
  logic        dmem_read;
  logic        dmem_write;
  logic        reg_write;
  logic        pc_inc;
  logic        pc_load;
  logic        pc_vector;
  logic        halted;
  logic [2:0]  state;
  logic [15:0] vec_addr;

  // master is the sequencer itself; slave is the datapath side
  modport master (
    input  id, cond_pass, resume,
    output ir_load, imem_read, dmem_read, dmem_write, reg_write,
           pc_inc, pc_load, pc_vector, halted, state, vec_addr
  );

  modport slave (
    output id, cond_pass, resume,
    input  ir_load, imem_read, dmem_read, dmem_write, reg_write,
           pc_inc, pc_load, pc_vector, halted, state, vec_addr
  );
endinterface

// File: rtl/instruction_sequencer_id_classifier.sv
// rtl/instruction_sequencer_id_classifier.sv - combinational map from decoder ID to instruction class
module id_classifier
  import instruction_sequencer_pkg::*;
(
  input  logic [6:0]   id_i,
  output instr_class_e class_o
);

  always_comb begin
    class_o = CLS_ILLEGAL;
    // BX sits inside the ALU range, so branches are resolved first
    if (id_i == ID_BX || id_i == ID_B) begin
      class_o = CLS_BRANCH;
    end else if (id_i >= 7'h01 && id_i <= 7'h27) begin
      class_o = CLS_ALU;
    end else if ((id_i >= 7'h2B && id_i <= 7'h2F) ||
                 (id_i inside {7'h31, 7'h33, 7'h35, 7'h37, 7'h39})) begin
      class_o = CLS_LOAD;
    end else if (id_i inside {7'h28, 7'h29, 7'h2A, 7'h30, 7'h32, 7'h34, 7'h36, 7'h38}) begin
      class_o = CLS_STORE;
    end else if (id_i >= 7'h3A && id_i <= 7'h47) begin
      class_o = CLS_MISC;
    end else if (id_i == ID_SWI) begin
      class_o = CLS_SWI;
    end else if (id_i == ID_NOP) begin
      class_o = CLS_NOP;
    end else if (id_i == ID_HLT) begin
      class_o = CLS_HLT;
    end else if (id_i == ID_RSTW) begin
      class_o = CLS_RSTW;
    end
  end

endmodule

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - multi-cycle fetch/decode/execute/memory/writeback control FSM
// Define SEQ_ILLEGAL_TRAP_EN to vector illegal IDs through TRAP instead of treating them as NOP.
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 2,
  parameter logic [15:0] SWI_VECTOR  = 16'h0009
)(
  input logic                     clock,
  input logic                     reset,
  instruction_sequencer_if.master bus
);

  localparam logic [3:0] LAT_LAST = 4'(MEM_LATENCY - 1);

  seq_state_e   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  instr_class_e cls_q, cls_d;
  instr_class_e id_cls;
  logic         res_meta_q, res_sync_q, res_prev_q;
  logic         res_rise;

  logic ir_load, imem_read, dmem_read, dmem_write, reg_write;
  logic pc_inc, pc_load, pc_vector, halted;

  id_classifier u_id_classifier (
    .id_i    (bus.id),
    .class_o (id_cls)
  );

  assign res_rise = res_sync_q & ~res_prev_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RESET;
      cnt_q      <= '0;
      cls_q      <= CLS_ILLEGAL;
      res_meta_q <= 1'b0;
      res_sync_q <= 1'b0;
      res_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cls_q      <= cls_d;
      res_meta_q <= bus.resume;
      res_sync_q <= res_meta_q;
      res_prev_q <= res_sync_q;
    end
  end

  // Outputs decode the registered state, counter and class
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cls_d      = cls_q;
    ir_load    = 1'b0;
    imem_read  = 1'b0;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    reg_write  = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    pc_vector  = 1'b0;
    halted     = 1'b0;

    case (state_q)
      ST_RESET: state_d = ST_FETCH;

      ST_FETCH: begin
        imem_read = 1'b1;
        if (cnt_q == LAT_LAST) begin
          ir_load = 1'b1;
          cnt_d   = '0;
          state_d = ST_DECODE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_DECODE: begin
        cls_d   = id_cls;
        state_d = ST_EXECUTE;
      end

      ST_EXECUTE: begin
        case (cls_q)
          CLS_ALU, CLS_MISC: begin
            reg_write = 1'b1;
            pc_inc    = 1'b1;
            state_d   = ST_FETCH;
          end
          CLS_BRANCH: begin
            pc_load = bus.cond_pass;
            pc_inc  = ~bus.cond_pass;
            state_d = ST_FETCH;
          end
          CLS_LOAD, CLS_STORE: state_d = ST_MEMORY;
          CLS_SWI:             state_d = ST_TRAP;
          CLS_HLT:             state_d = ST_HALT;
          CLS_RSTW:            state_d = ST_RESET;
          CLS_ILLEGAL: begin
`ifdef SEQ_ILLEGAL_TRAP_EN
            state_d = ST_TRAP;
`else
            pc_inc  = 1'b1;
            state_d = ST_FETCH;
`endif
          end
          default: begin
            pc_inc  = 1'b1;
            state_d = ST_FETCH;
          end
        endcase
      end

      ST_MEMORY: begin
        dmem_read  = (cls_q == CLS_LOAD);
        dmem_write = (cls_q == CLS_STORE);
        if (cnt_q == LAT_LAST) begin
          cnt_d   = '0;
          state_d = ST_WRITEBACK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_WRITEBACK: begin
        reg_write = (cls_q == CLS_LOAD);
        pc_inc    = 1'b1;
        state_d   = ST_FETCH;
      end

      // halted drops in the release cycle so it never overlaps pc_inc
      ST_HALT: begin
        halted = ~res_rise;
        if (res_rise) begin
          pc_inc  = 1'b1;
          state_d = ST_FETCH;
        end
      end

      ST_TRAP: begin
        reg_write = 1'b1;
        pc_vector = 1'b1;
        state_d   = ST_FETCH;
      end

      default: state_d = ST_RESET;
    endcase
  end

  assign bus.ir_load    = ir_load;
  assign bus.imem_read  = imem_read;
  assign bus.dmem_read  = dmem_read;
  assign bus.dmem_write = dmem_write;
  assign bus.reg_write  = reg_write;
  assign bus.pc_inc     = pc_inc;
  assign bus.pc_load    = pc_load;
  assign bus.pc_vector  = pc_vector;
  assign bus.halted     = halted;
  assign bus.state      = state_q;
  assign bus.vec_addr   = SWI_VECTOR;

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - self-checking bench for instruction_sequencer
module tb_instruction_sequencer;
  import instruction_sequencer_pkg::*;

  localparam int ML = 2;
  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BRANCH = 3, K_SWI = 4;
  localparam int K_NOP = 5, K_HLT = 6, K_RSTW = 7, K_MISC = 8, K_ILL = 9;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  instruction_sequencer_if bus ();

  instruction_sequencer #(.MEM_LATENCY(ML), .SWI_VECTOR(16'h0009)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [6:0]   cls_id;
  instr_class_e cls_o;
  id_classifier u_cls (.id_i(cls_id), .class_o(cls_o));

  always #5 clock = ~clock;

  logic [6:0] dir_id [0:17] = '{7'h04, 7'h31, 7'h49, 7'h49, 7'h4B, 7'h7F, 7'h48, 7'h28,
                                7'h4A, 7'h64, 7'h26, 7'h26, 7'h00, 7'h3A, 7'h47, 7'h2F,
                                7'h38, 7'h27};
  bit         dir_cp [0:17] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_class(input int v);
    if (v == 'h26 || v == 'h49) return K_BRANCH;
    if (v >= 'h01 && v <= 'h27) return K_ALU;
    if ((v >= 'h2B && v <= 'h2F) || (v >= 'h31 && v <= 'h39 && v % 2 == 1)) return K_LOAD;
    if ((v >= 'h28 && v <= 'h2A) || (v >= 'h30 && v <= 'h38 && v % 2 == 0)) return K_STORE;
    if (v >= 'h3A && v <= 'h47) return K_MISC;
    if (v == 'h48) return K_SWI;
    if (v == 'h4A) return K_NOP;
    if (v == 'h4B) return K_HLT;
    if (v == 'h64) return K_RSTW;
    return K_ILL;
  endfunction

  function automatic int map_cls(input instr_class_e c);
    case (c)
      CLS_ALU:    return K_ALU;
      CLS_LOAD:   return K_LOAD;
      CLS_STORE:  return K_STORE;
      CLS_BRANCH: return K_BRANCH;
      CLS_SWI:    return K_SWI;
      CLS_NOP:    return K_NOP;
      CLS_HLT:    return K_HLT;
      CLS_RSTW:   return K_RSTW;
      CLS_MISC:   return K_MISC;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic logic [31:0] outs();
    return 32'({bus.ir_load, bus.imem_read, bus.dmem_read, bus.dmem_write, bus.reg_write,
                bus.pc_inc, bus.pc_load, bus.pc_vector, bus.halted});
  endfunction

  // Starts on a negedge with the DUT at the first FETCH cycle of an instruction
  task automatic run_instr(input logic [6:0] id_v, input bit cp);
    int k, cyc, ir_cyc, pc_cyc, rw_cyc;
    int n_imem, n_ir, n_dr, n_dw, n_rw, n_inc, n_ld, n_vec, n_multi;
    int e_dr, e_dw, e_rw, e_inc, e_ld, e_vec, e_cyc, e_end;
    bit left, done;
    string s;
    k = exp_class(int'(id_v));
    s = $sformatf("id%02h_cp%0d", id_v, cp);
    {cyc, ir_cyc, pc_cyc, rw_cyc} = {32'd0, -32'sd1, -32'sd1, -32'sd1};
    {n_imem, n_ir, n_dr, n_dw, n_rw, n_inc, n_ld, n_vec, n_multi} = '0;
    left = 1'b0;
    done = 1'b0;
    bus.id = id_v;
    bus.cond_pass = cp;
    check({"fetch_entry_", s}, 32'(bus.state), 32'd1);
    while (!done && cyc < 200) begin
      cyc++;
      n_imem += int'(bus.imem_read);
      n_ir   += int'(bus.ir_load);
      n_dr   += int'(bus.dmem_read);
      n_dw   += int'(bus.dmem_write);
      n_rw   += int'(bus.reg_write);
      n_inc  += int'(bus.pc_inc);
      n_ld   += int'(bus.pc_load);
      n_vec  += int'(bus.pc_vector);
      if (bus.ir_load) ir_cyc = cyc;
      if (bus.pc_inc || bus.pc_load || bus.pc_vector) pc_cyc = cyc;
      if (bus.reg_write) rw_cyc = cyc;
      if (int'(bus.pc_inc) + int'(bus.pc_load) + int'(bus.pc_vector) > 1) n_multi++;
      @(negedge clock);
      if (bus.state != 3'd1) left = 1'b1;
      else if (left) done = 1'b1;
      if (bus.state == 3'd6) done = 1'b1;
    end

    {e_dr, e_dw, e_rw, e_inc, e_ld, e_vec} = '0;
    e_cyc = ML + 2;
    e_end = 1;
    case (k)
      K_ALU, K_MISC: begin e_rw = 1; e_inc = 1; end
      K_BRANCH:      begin e_inc = cp ? 0 : 1; e_ld = cp ? 1 : 0; end
      K_NOP:         e_inc = 1;
      K_SWI:         begin e_rw = 1; e_vec = 1; e_cyc = ML + 3; end
      K_LOAD:        begin e_dr = ML; e_rw = 1; e_inc = 1; e_cyc = 2 * ML + 3; end
      K_STORE:       begin e_dw = ML; e_inc = 1; e_cyc = 2 * ML + 3; end
      K_HLT:         e_end = 6;
      K_RSTW:        e_cyc = ML + 3;
      default: begin
`ifdef SEQ_ILLEGAL_TRAP_EN
        e_rw = 1; e_vec = 1; e_cyc = ML + 3;
`else
        e_inc = 1;
`endif
      end
    endcase

    check({"done_", s},       32'(done), 32'd1);
    check({"cycles_", s},     32'(cyc), 32'(e_cyc));
    check({"end_state_", s},  32'(bus.state), 32'(e_end));
    check({"imem_", s},       32'(n_imem), 32'(ML));
    check({"ir_load_", s},    32'(n_ir), 32'd1);
    check({"ir_cycle_", s},   32'(ir_cyc), 32'(ML));
    check({"dmem_read_", s},  32'(n_dr), 32'(e_dr));
    check({"dmem_write_", s}, 32'(n_dw), 32'(e_dw));
    check({"reg_write_", s},  32'(n_rw), 32'(e_rw));
    check({"pc_inc_", s},     32'(n_inc), 32'(e_inc));
    check({"pc_load_", s},    32'(n_ld), 32'(e_ld));
    check({"pc_vector_", s},  32'(n_vec), 32'(e_vec));
    check({"pc_excl_", s},    32'(n_multi), 32'd0);
    if (e_inc + e_ld + e_vec > 0) check({"pc_cycle_", s}, 32'(pc_cyc), 32'(e_cyc));
    if (e_rw > 0) check({"rw_cycle_", s}, 32'(rw_cyc), 32'(e_cyc));
  endtask

  // Starts on a negedge with the DUT in HALT
  task automatic do_halt(input int hold, input bit pre_high);
    int lat;
    bit seen;
    for (int i = 0; i < hold; i++) begin
      check("halt_hold", 32'({bus.halted, bus.state}), 32'({1'b1, 3'd6}));
      check("halt_pc_quiet", 32'({bus.pc_inc, bus.pc_load, bus.pc_vector, bus.reg_write}), 32'd0);
      @(negedge clock);
    end
    if (pre_high) begin
      bus.resume = 1'b0;
      repeat (3) @(negedge clock);
      check("halt_after_drop", 32'(bus.halted), 32'd1);
    end
    bus.resume = 1'b1;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clock);
      lat++;
      if (bus.pc_inc) seen = 1'b1;
    end
    check("resume_latency", 32'(lat), 32'd2);
    check("resume_release", 32'({bus.pc_inc, bus.halted}), 32'({1'b1, 1'b0}));
    @(negedge clock);
    check("resume_fetch", 32'(bus.state), 32'd1);
    bus.resume = 1'b0;
  endtask

  task automatic step(input logic [6:0] id_v, input bit cp);
    run_instr(id_v, cp);
    if (exp_class(int'(id_v)) == K_HLT) do_halt(int'($urandom_range(3, 12)), 1'b0);
  endtask

  initial begin
    int cnt;
    bus.id = '0;
    bus.cond_pass = 1'b0;
    bus.resume = 1'b0;
    cls_id = '0;

    repeat (3) @(negedge clock);
    check("reset_outs", outs(), 32'd0);
    check("reset_state", 32'(bus.state), 32'd0);
    check("vec_addr", 32'(bus.vec_addr), 32'h0009);
    reset = 1'b1;
    #1 check("release_state", 32'(bus.state), 32'd0);
    @(negedge clock);
    check("first_fetch", 32'({bus.state, bus.imem_read}), 32'({3'd1, 1'b1}));

    #2 reset = 1'b0;
    #1 check("midfetch_outs", outs(), 32'd0);
    check("midfetch_state", 32'(bus.state), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    #1 check("rerelease_state", 32'(bus.state), 32'd0);
    @(negedge clock);

    for (int i = 0; i < 18; i++) step(dir_id[i], dir_cp[i]);

    bus.id = 7'h31;
    cnt = 0;
    while (bus.state != 3'd4 && cnt < 20) begin
      @(negedge clock);
      cnt++;
    end
    check("mem_reached", 32'({bus.state, bus.dmem_read}), 32'({3'd4, 1'b1}));
    #2 reset = 1'b0;
    #1 check("midmem_outs", outs(), 32'd0);
    check("midmem_state", 32'(bus.state), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midmem_refetch", 32'(bus.state), 32'd1);

    bus.resume = 1'b1;
    run_instr(7'h4B, 1'b0);
    do_halt(8, 1'b1);

    for (int i = 0; i < 40; i++) step(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)));

    for (int i = 0; i < 128; i++) begin
      cls_id = 7'(i);
      #1 check($sformatf("class_%02h", i), 32'(map_cls(cls_o)), 32'(exp_class(i)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
